// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared types and lane constants for the pair scheduler
package mult_sched_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } sched_state_e;

    localparam int LANES  = 2;
    localparam int HALF_W = 4;
    localparam int FULL_W = 8;
    localparam int PROD_W = 2 * FULL_W;

endpackage

// File: rtl/config_multiplier_8bit.sv
// rtl/config_multiplier_8bit.sv - combinational signed multiplier, one 8x8 or two packed 4x4 lanes
module config_multiplier_8bit
    import mult_sched_pkg::*;
(
    input  logic [FULL_W-1:0] a,
    input  logic [FULL_W-1:0] b,
    input  logic              halved_precision,
    output logic [PROD_W-1:0] p
);

    logic signed [PROD_W-1:0] full_p;
    logic signed [FULL_W-1:0] lo_p;
    logic signed [FULL_W-1:0] hi_p;

    assign full_p = $signed(a) * $signed(b);
    assign lo_p   = $signed(a[HALF_W-1:0]) * $signed(b[HALF_W-1:0]);
    assign hi_p   = $signed(a[FULL_W-1:HALF_W]) * $signed(b[FULL_W-1:HALF_W]);

    assign p = halved_precision ? {hi_p, lo_p} : full_p;

endmodule

// File: rtl/mult_pair_scheduler.sv
// rtl/mult_pair_scheduler.sv - packs consecutive half-precision requests into one multiply
module mult_pair_scheduler
    import mult_sched_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FULL_W-1:0] in_a,
    input  logic [FULL_W-1:0] in_b,
    input  logic              in_half,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_half,
    output logic [LANES-1:0]  out_lane_valid,
    output logic [PROD_W-1:0] out_p,
    output logic [TAG_W-1:0]  out_tag0,
    output logic [TAG_W-1:0]  out_tag1
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WCNT_MAX = CNT_W'(TIMEOUT);

    sched_state_e      state, state_n;
    logic [HALF_W-1:0] pend_a, pend_a_n;
    logic [HALF_W-1:0] pend_b, pend_b_n;
    logic [TAG_W-1:0]  pend_tag, pend_tag_n;
    logic [CNT_W-1:0]  wcnt, wcnt_n;

    logic              slot_free;
    logic              accept;
    logic              issue;
    logic [FULL_W-1:0] mul_a;
    logic [FULL_W-1:0] mul_b;
    logic              mul_half;
    logic [PROD_W-1:0] mul_p;
    logic [LANES-1:0]  beat_mask;
    logic [TAG_W-1:0]  beat_tag0;
    logic [TAG_W-1:0]  beat_tag1;

    assign slot_free = !out_valid || out_ready;

    // Halves never wait on the slot in IDLE: they only park in the pending register.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state == S_IDLE) in_ready = in_half || slot_free;
            else                 in_ready = in_half && slot_free;
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_n    = state;
        pend_a_n   = pend_a;
        pend_b_n   = pend_b;
        pend_tag_n = pend_tag;
        wcnt_n     = wcnt;
        issue      = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        mul_half   = 1'b0;
        beat_mask  = 2'b01;
        beat_tag0  = pend_tag;
        beat_tag1  = '0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_half) begin
                        pend_a_n   = in_a[HALF_W-1:0];
                        pend_b_n   = in_b[HALF_W-1:0];
                        pend_tag_n = in_tag;
                        wcnt_n     = '0;
                        state_n    = S_HOLD;
                    end else begin
                        issue     = 1'b1;
                        mul_a     = in_a;
                        mul_b     = in_b;
                        beat_tag0 = in_tag;
                    end
                end
            end
            S_HOLD: begin
                mul_half = 1'b1;
                mul_a    = {{HALF_W{1'b0}}, pend_a};
                mul_b    = {{HALF_W{1'b0}}, pend_b};
                if (accept) begin
                    // The pending request is older, so it always takes lane0.
                    issue     = 1'b1;
                    mul_a     = {in_a[HALF_W-1:0], pend_a};
                    mul_b     = {in_b[HALF_W-1:0], pend_b};
                    beat_mask = 2'b11;
                    beat_tag1 = in_tag;
                    wcnt_n    = '0;
                    state_n   = S_IDLE;
                end else if (slot_free && ((in_valid && !in_half) || wcnt == WCNT_MAX)) begin
                    issue   = 1'b1;
                    wcnt_n  = '0;
                    state_n = S_IDLE;
                end else if (wcnt != WCNT_MAX) begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    config_multiplier_8bit u_mult (
        .a                (mul_a),
        .b                (mul_b),
        .halved_precision (mul_half),
        .p                (mul_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pend_a   <= '0;
            pend_b   <= '0;
            pend_tag <= '0;
            wcnt     <= '0;
        end else begin
            state    <= state_n;
            pend_a   <= pend_a_n;
            pend_b   <= pend_b_n;
            pend_tag <= pend_tag_n;
            wcnt     <= wcnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_half       <= 1'b0;
            out_lane_valid <= '0;
            out_p          <= '0;
            out_tag0       <= '0;
            out_tag1       <= '0;
        end else if (issue) begin
            out_valid      <= 1'b1;
            out_half       <= mul_half;
            out_lane_valid <= beat_mask;
            out_p          <= mul_p;
            out_tag0       <= beat_tag0;
            out_tag1       <= beat_tag1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult_pair_scheduler.sv
// tb/tb_mult_pair_scheduler.sv - directed and randomised checks of the pair scheduler
module tb_mult_pair_scheduler;

    localparam int NREQ = 1000;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       half;
        logic [3:0] tag;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_half;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic        out_half;
    logic [1:0]  out_lane_valid;
    logic [15:0] out_p;
    logic [3:0]  out_tag0;
    logic [3:0]  out_tag1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_pair_scheduler #(.TAG_W(4), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_half        (in_half),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_half       (out_half),
        .out_lane_valid (out_lane_valid),
        .out_p          (out_p),
        .out_tag0       (out_tag0),
        .out_tag1       (out_tag1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic h, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] t);
        in_valid = v;
        in_half  = h;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
    endtask

    function automatic logic [7:0] lane_p(input req_t r);
        logic signed [7:0] v;
        v = $signed(r.a[3:0]) * $signed(r.b[3:0]);
        return v;
    endfunction

    function automatic logic [15:0] full_p(input req_t r);
        logic signed [15:0] v;
        v = $signed(r.a) * $signed(r.b);
        return v;
    endfunction

    req_t q[$];
    req_t cur, r0, r1;
    logic have;
    int   sent;
    int   beats;
    logic [3:0] tagc;
    logic [15:0] exp_p;
    logic [7:0]  exp_tag1;
    logic [2:0]  exp_meta;

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 1'b1, 8'h00, 8'h00, 4'h0);
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_fields", {out_p, out_tag0, out_tag1, out_lane_valid, out_half}, '0);
        out_ready = 1'b1;

        // full -128 * -1
        drive(1'b1, 1'b0, 8'h80, 8'hFF, 4'd3);
        #1;
        check("full_in_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        check("full_valid", out_valid, 1'b1);
        check("full_p", out_p, 16'h0080);
        check("full_meta", {out_half, out_lane_valid, out_tag0, out_tag1}, {1'b0, 2'b01, 4'd3, 4'd0});
        tick();
        check("full_drained", out_valid, 1'b0);

        // packed pair (7,-7) then (3,4)
        drive(1'b1, 1'b1, 8'h07, 8'hF9, 4'd1);
        tick();
        drive(1'b1, 1'b1, 8'h03, 8'h04, 4'd2);
        #1;
        check("pair_in_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        check("pair_valid", out_valid, 1'b1);
        check("pair_p", out_p, 16'h0CCF);
        check("pair_meta", {out_half, out_lane_valid, out_tag0, out_tag1}, {1'b1, 2'b11, 4'd1, 4'd2});
        tick();

        // lone half (-8,7): result in t+10
        drive(1'b1, 1'b1, 8'h08, 8'h07, 4'd5);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        for (int i = 1; i <= 9; i++) begin
            check($sformatf("lone_wait_%0d", i), out_valid, 1'b0);
            tick();
        end
        check("lone_valid", out_valid, 1'b1);
        check("lone_p", out_p, 16'h00C8);
        check("lone_meta", {out_half, out_lane_valid, out_tag0, out_tag1}, {1'b1, 2'b01, 4'd5, 4'd0});
        tick();

        // half (4,-2) flushed by a following full (127,127)
        drive(1'b1, 1'b1, 8'h04, 8'hFE, 4'd6);
        tick();
        drive(1'b1, 1'b0, 8'h7F, 8'h7F, 4'd7);
        #1;
        check("flush_full_blocked", in_ready, 1'b0);
        tick();
        check("flush_p", out_p, 16'h00F8);
        check("flush_meta", {out_valid, out_half, out_lane_valid, out_tag0, out_tag1},
              {1'b1, 1'b1, 2'b01, 4'd6, 4'd0});
        check("flush_full_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        check("flush_full_p", out_p, 16'h3F01);
        check("flush_full_tag", {out_valid, out_tag0}, {1'b1, 4'd7});
        tick();

        // backpressure with a pair in the output slot
        drive(1'b1, 1'b1, 8'h01, 8'h02, 4'd8);
        tick();
        drive(1'b1, 1'b1, 8'hFD, 8'h05, 4'd9);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h0A, 8'hFD, 4'd10);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_in_ready_%0d", i), in_ready, 1'b0);
            check($sformatf("bp_hold_%0d", i), {out_valid, out_lane_valid, out_p, out_tag0, out_tag1},
                  {1'b1, 2'b11, 16'hF102, 4'd8, 4'd9});
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        check("bp_full_p", out_p, 16'hFFE2);
        check("bp_full_tag", {out_valid, out_lane_valid, out_tag0}, {1'b1, 2'b01, 4'd10});
        tick();

        // reset while HOLD with a full output slot
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h05, 8'h05, 4'd11);
        tick();
        drive(1'b1, 1'b1, 8'h01, 8'h01, 4'd12);
        tick();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_idle", in_ready, 1'b1);
        out_ready = 1'b1;
        beats = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) beats++;
        end
        check("mrst_no_emit", beats, 0);

        // random traffic against a reference queue
        have = 1'b0;
        sent = 0;
        tagc = 4'd0;
        for (int cyc = 0; cyc < 30000 && !(sent == NREQ && q.size() == 0); cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!have && sent < NREQ && $urandom_range(0, 3) != 0) begin
                cur.a    = 8'($urandom);
                cur.b    = 8'($urandom);
                cur.half = ($urandom_range(0, 9) < 6);
                cur.tag  = tagc;
                tagc     = tagc + 4'd1;
                have     = 1'b1;
            end
            drive(have, cur.half, cur.a, cur.b, cur.tag);
            #3;
            if (in_valid && in_ready) begin
                q.push_back(cur);
                have = 1'b0;
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_underflow", q.size(), 1);
                end else begin
                    r0 = q.pop_front();
                    if (!r0.half) begin
                        exp_p    = full_p(r0);
                        exp_tag1 = {4'd0, r0.tag};
                        exp_meta = 3'b001;
                    end else if (out_lane_valid == 2'b11 && q.size() != 0) begin
                        r1 = q.pop_front();
                        check("rnd_lane1_half", r1.half, 1'b1);
                        exp_p    = {lane_p(r1), lane_p(r0)};
                        exp_tag1 = {r1.tag, r0.tag};
                        exp_meta = 3'b111;
                    end else begin
                        exp_p    = {8'h00, lane_p(r0)};
                        exp_tag1 = {4'd0, r0.tag};
                        exp_meta = 3'b101;
                    end
                    check("rnd_p", out_p, exp_p);
                    check("rnd_tags", {out_tag1, out_tag0}, exp_tag1);
                    check("rnd_meta", {out_half, out_lane_valid}, exp_meta);
                end
            end
            @(posedge clk);
            #1;
        end
        check("rnd_drained", {sent == NREQ, q.size() == 0}, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
